reg_file_dff: RTL and testbench
===============================

// Module: reg_file_dff
// PURPOSE
//  - Storage stage downstream of the gated D-latch cells: a bank of DEPTH edge-triggered WIDTH-bit registers.
//  - Each register is built from a master/slave register cell and loaded from the CPU write bus.
//  - Two independent read ports feed the ALU operand buses of the 16-bit CPU datapath.
//  - One write port per cycle, driven by the control unit on the rising clk edge.
// PARAMETERS
//  - WIDTH    16  data width of each register
//  - DEPTH     8  number of registers; power of two
//  - AW        3  address width, $clog2(DEPTH)
//  - ZERO_R0   0  1: register 0 always reads 0 and ignores writes
// PORTS
//  - clk        in   1      rising-edge clock
//  - resetn     in   1      reset, asynchronous, active-low
//  - wr_en      in   1      write strobe, sampled on rising clk
//  - wr_addr    in   AW     write register index
//  - wr_data    in   WIDTH  write data
//  - rd_addr_a  in   AW     read port A index
//  - rd_data_a  out  WIDTH  read port A data
//  - rd_addr_b  in   AW     read port B index
//  - rd_data_b  out  WIDTH  read port B data
//  - wr_count   out  8      saturating count of accepted writes (debug)
// BEHAVIOUR
//  - Reset: resetn low asynchronously clears all registers to 0 and wr_count to 0.
//    rd_data_a/b therefore read 0 during and immediately after reset.
//  - Reset mid-write: resetn low wins over any write in the same edge.
//    No register keeps the write data.
//  - Write: on rising clk with wr_en=1 and resetn=1, reg[wr_addr] <= wr_data.
//    Latency 1 cycle.
//  - wr_en=0: all registers hold their values; wr_en is the only load enable, with no gating of clk.
//  - Read: combinational. rd_data_x = reg[rd_addr_x] of the current stored value.
//  - A=B address: both ports return the same value; there is no conflict.
//  - ZERO_R0=1: writes to address 0 are discarded and do not count in wr_count.
//    Reads of address 0 return 0.
//  - wr_count: increments by 1 on each accepted write and saturates at 8'hFF.
//  - X/Z on wr_addr while wr_en=1 is illegal; an assertion flags it in simulation.
// CONFIGURATION
//  - Macro RF_WRITE_BYPASS_EN.
//  - Defined: when wr_en=1 and rd_addr_x==wr_addr, rd_data_x = wr_data in the same cycle (write-through forwarding).
//    The ZERO_R0 rule still takes priority.
//  - Undefined: reads return the old stored value until the next edge, i.e. write-then-read needs 1 cycle.
// STRUCTURE
//  - Package cpu_pkg:
//    - WIDTH_C=16, AW_C=3
//    - typedef logic [15:0] word_t
//    - typedef logic [2:0] reg_idx_t
//    - localparam word_t ZERO_WORD
//  - Sub-module reg_cell: WIDTH-bit D register with load enable and async active-low clear.
//    Instantiated DEPTH times under a generate loop.
//  - Top level contains the write-address decoder, two read muxes, the optional bypass and wr_count.
// TESTING
//  - Reset: hold resetn=0 and drive wr_en=1, wr_data=16'hFFFF -> all reads 16'h0000, wr_count=0.
//  - Write/read sweep: write reg[i]=16'h1111*i for i=0..7, then read all on A and B.
//    Expect 16'h0000..16'h7777 and wr_count=8 (7 and reg0=0 if ZERO_R0=1).
//  - Hold: wr_en=0 with wr_addr=3, wr_data=16'hDEAD for 4 cycles -> reg3 unchanged (16'h3333).
//  - Read-during-write: write reg5=16'hA5A5 with rd_addr_a=5.
//    With RF_WRITE_BYPASS_EN: A=16'hA5A5 in the same cycle.
//    Without it: A=16'h5555 until the edge, then 16'hA5A5.
//  - Async reset mid-run: assert resetn=0 between clk edges after the sweep -> reads go 0 immediately, with no edge needed.
//  - Saturation: 300 writes -> wr_count=8'hFF and stays there.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath types and sizes for the 16-bit CPU register file.
package cpu_pkg;

  localparam int WIDTH_C = 16;
  localparam int AW_C    = 3;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  localparam word_t ZERO_WORD = 16'h0000;

endpackage

// File: rtl/reg_cell.sv
// One WIDTH-bit edge-triggered storage register with load enable and async active-low clear.
module reg_cell
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_C
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_dff.sv
// DEPTH x WIDTH register file: one write port, two combinational read ports, saturating write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_WRITE_BYPASS_EN.
module reg_file_dff
  import cpu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_C,
  parameter int DEPTH   = 8,
  parameter int AW      = AW_C,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [7:0]       wr_count
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic             wr_accept;
  logic [7:0]       wr_count_q;
  logic [7:0]       wr_count_d;

  // With ZERO_R0, writes to r0 are dropped here so they neither store nor count.
  assign wr_accept = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    assign load[gi] = wr_accept && (wr_addr == AW'(gi));

    reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk    (clk),
      .resetn (resetn),
      .load_i (load[gi]),
      .d_i    (wr_data),
      .q_o    (regs_q[gi])
    );
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
    if (wr_en && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
`endif
    // The zero-register rule overrides forwarding.
    if ((ZERO_R0 != 0) && (rd_addr_a == '0)) rd_data_a = '0;
    if ((ZERO_R0 != 0) && (rd_addr_b == '0)) rd_data_b = '0;
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_accept && (wr_count_q != 8'hFF)) wr_count_d = wr_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_count_q <= 8'h00;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  a_wr_addr_known : assert property (
    @(posedge clk) disable iff (!resetn) wr_en |-> !$isunknown(wr_addr)
  ) else $error("reg_file_dff: wr_addr unknown while wr_en=1");

endmodule

// File: tb/tb_reg_file_dff.sv
// Scoreboard bench for reg_file_dff: stimulus pushes expected reads/counts, a negedge monitor pops and compares.
module tb_reg_file_dff;

  localparam int ZR0 = 0;

  logic        clk;
  logic        resetn;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic [7:0]  wr_count;

  reg_file_dff #(
    .WIDTH   (16),
    .DEPTH   (8),
    .AW      (3),
    .ZERO_R0 (ZR0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // port: 0 = read A, 1 = read B, 2 = wr_count
  typedef struct {
    string       name;
    int          port;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push_exp(input string name, input int port, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Checks are sampled on the falling edge, half a cycle after stimulus changes.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb.pop_front();
      case (e.port)
        0:       act = rd_data_a;
        1:       act = rd_data_b;
        default: act = {8'h00, wr_count};
      endcase
      n_checks++;
      if (act === e.exp) begin
        n_pass++;
        $display("[%0t] ok   %s got=%h", $time, e.name, act);
      end else begin
        $display("[%0t] FAIL %s got=%h expected=%h", $time, e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sweep_val(input int i);
    logic [15:0] v;
    v = 16'h1111 * i[15:0];
    if ((ZR0 != 0) && (i == 0)) v = 16'h0000;
    return v;
  endfunction

  initial begin
    resetn    = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 3'd0;
    wr_data   = 16'hFFFF;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;

    // Reset held while a write is being driven: nothing may store.
    for (int i = 0; i < 4; i++) begin
      step();
      wr_addr   = 3'(i * 2);
      rd_addr_a = 3'(i * 2);
      rd_addr_b = 3'(7 - i * 2);
      push_exp($sformatf("reset_rdA[%0d]", i * 2), 0, 16'h0000);
      push_exp($sformatf("reset_rdB[%0d]", 7 - i * 2), 1, 16'h0000);
      push_exp("reset_count", 2, 16'h0000);
    end

    step();
    wr_en  = 1'b0;
    resetn = 1'b1;

    // Write sweep.
    for (int i = 0; i < 8; i++) begin
      step();
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 16'h1111 * 16'(i);
    end
    step();
    wr_en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step();
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      push_exp($sformatf("sweep_rdA[%0d]", i), 0, sweep_val(i));
      push_exp($sformatf("sweep_rdB[%0d]", 7 - i), 1, sweep_val(7 - i));
    end
    push_exp("sweep_count", 2, (ZR0 != 0) ? 16'd7 : 16'd8);

    // Hold: wr_en low with a live-looking address/data must not load.
    for (int i = 0; i < 4; i++) begin
      step();
      wr_en     = 1'b0;
      wr_addr   = 3'd3;
      wr_data   = 16'hDEAD;
      rd_addr_a = 3'd3;
      rd_addr_b = 3'd3;
      push_exp($sformatf("hold_rdA3_c%0d", i), 0, 16'h3333);
      push_exp($sformatf("hold_rdB3_c%0d", i), 1, 16'h3333);
    end
    push_exp("hold_count", 2, (ZR0 != 0) ? 16'd7 : 16'd8);

    // Read during write to r5.
    step();
    wr_en     = 1'b1;
    wr_addr   = 3'd5;
    wr_data   = 16'hA5A5;
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd4;
`ifdef RF_WRITE_BYPASS_EN
    push_exp("rdw_same_cycle_A", 0, 16'hA5A5);
`else
    push_exp("rdw_same_cycle_A", 0, 16'h5555);
`endif
    push_exp("rdw_other_B", 1, 16'h4444);
    step();
    wr_en = 1'b0;
    push_exp("rdw_after_edge_A", 0, 16'hA5A5);
    push_exp("rdw_count", 2, (ZR0 != 0) ? 16'd8 : 16'd9);

    // Async reset between edges: reads drop without any clock edge.
    step();
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd3;
    #1;
    resetn = 1'b0;
    push_exp("async_rst_A", 0, 16'h0000);
    push_exp("async_rst_B", 1, 16'h0000);
    push_exp("async_rst_count", 2, 16'h0000);
    step();
    resetn = 1'b1;

    // Same address on both ports.
    step();
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 16'h1234;
    step();
    wr_en     = 1'b0;
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd2;
    push_exp("same_addr_A", 0, 16'h1234);
    push_exp("same_addr_B", 1, 16'h1234);
    push_exp("same_addr_count", 2, 16'd1);

    // Saturation: 300 more writes to nonzero registers.
    for (int i = 0; i < 300; i++) begin
      step();
      wr_en   = 1'b1;
      wr_addr = 3'((i % 7) + 1);
      wr_data = 16'(i);
    end
    step();
    wr_en = 1'b0;
    push_exp("sat_count", 2, 16'h00FF);
    step();
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 16'hBEEF;
    step();
    wr_en     = 1'b0;
    rd_addr_a = 3'd1;
    push_exp("sat_stays_count", 2, 16'h00FF);
    push_exp("sat_last_write_A", 0, 16'hBEEF);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
